mp_mult_sequencer: RTL and testbench
====================================

Name: mp_mult_sequencer

Overview:
Multi-precision multiply sequencer. It computes a 2W-bit unsigned product of two W-bit operands using the shared 16x16 AXI-stream pipelined multiplier. It splits the operands into 16-bit limbs, issues all limb-pair partial products to the multiplier, and accumulates the 32-bit results with the correct shifts. It sits between the ElGamal modular-arithmetic layer, which uses it as the operand/result stream, and the 16x16 multiplier core.

Parameters:
LIMBS, 4, operand limbs; W = 16*LIMBS (default 64-bit operands, 128-bit result)
MULT_LAT, 4, accepted beats between issuing a pair and its product appearing on mul_p_tdata (sampled at the edge of beat j+MULT_LAT)

Ports:
clk  in  1  clock
rst  in  1  reset
s_op_a_tdata  in  W  operand A
s_op_b_tdata  in  W  operand B
s_op_tvalid  in  1  operand pair valid
s_op_tready  out  1  operand pair accepted
m_res_tdata  out  2W  product A*B
m_res_tvalid  out  1  result valid
m_res_tready  in  1  result consumed
mul_a_tdata  out  16  limb to multiplier input A
mul_a_tvalid  out  1  multiplier A valid
mul_a_tready  in  1  multiplier A ready
mul_b_tdata  out  16  limb to multiplier input B
mul_b_tvalid  out  1  multiplier B valid
mul_b_tready  in  1  multiplier B ready
mul_p_tdata  in  32  multiplier product
mul_p_tvalid  in  1  multiplier product valid; ignored, since product alignment comes from the beat count
mul_p_tready  out  1  multiplier output ready
busy  out  1  job in progress (state != IDLE)

Behaviour:
- Reset: rst synchronous, active-high; clock clk. Outputs after reset:
  - state=IDLE, s_op_tready=1, m_res_tvalid=0, m_res_tdata=0.
  - mul_*_tvalid=0, mul_*_tdata=0, mul_p_tready=0, busy=0.
  - Accumulator=0, beat counter=0.
- States: IDLE -> ISSUE -> DONE -> IDLE.
- IDLE:
  - s_op_tready=1.
  - On s_op_tvalid: latch A and B, clear accumulator, beat counter j=0, go to ISSUE.
- ISSUE:
  - mul_a_tvalid=mul_b_tvalid=1 and mul_p_tready=1 throughout.
  - A beat is accepted on a cycle with mul_a_tready & mul_b_tready; j increments only on accepted beats.
  - While ready is low, operand data and j hold (stall).
  - Beat j < N (N=LIMBS*LIMBS): send i=j/LIMBS and k=j%LIMBS; mul_a_tdata=A[16i+:16], mul_b_tdata=B[16k+:16].
  - Beat j >= N: flush beat with both operands 0.
  - Capture: at the edge of accepted beat j with j >= MULT_LAT, sample mul_p_tdata (= product of beat p=j-MULT_LAT).
  - Accumulate: acc += mul_p_tdata << 16*(p/LIMBS + p%LIMBS). This is a 2W-bit add; no carry can exceed 2W.
  - Beats j < MULT_LAT sample stale pipeline contents and must be discarded.
  - After accepted beat j = N+MULT_LAT-1 (default 19), go to DONE.
- DONE:
  - m_res_tvalid=1, m_res_tdata=acc (registered, stable while valid).
  - mul_*_tvalid=0, s_op_tready=0.
  - On m_res_tready: go to IDLE, drop m_res_tvalid.
- Latency with default parameters and no stalls:
  - Accept at cycle 0; beats at cycles 1..20; m_res_tvalid at cycle 21.
  - Throughput: one job per 22 cycles plus result backpressure.
- s_op_tready is low outside IDLE. No new job is accepted in the cycle the result is consumed; the earliest next accept is the following cycle.
- Reset mid-ISSUE or mid-DONE: abort immediately to the reset values; a partially accumulated result is never presented. Stale multiplier contents are harmless because the first MULT_LAT captures are always discarded.
- Zero operands need no special case; the full beat sequence still runs.

Decomposition:
- Package mp_mult_pkg:
  - LIMB_W=16, PROD_W=32.
  - State enum {IDLE, ISSUE, DONE}.
  - Function for the limb-index split (i, k) from the beat index.
- No sub-module. The multiplier is instantiated by the parent and wired to the mul_* ports; the same rst drives both.

Test Plan:
- A=3, B=5 -> m_res_tdata=15; m_res_tvalid rises exactly 21 cycles after accept, with no stalls.
- A=B=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFFFFFFFFFFFFFE_0000000000000001.
- A=0x0001_0000_0000_0000, B=0x0000_0000_0001_0000 -> 0x1_0000_0000_0000_0000 (cross-limb shift).
- Back-to-back jobs (7*9 then 0x1234*0x10000) with m_res_tready=1 -> 63 then 0x12340000; s_op_tready low during each job.
- Random mul ready deassertion during ISSUE (50% duty), A=0xDEADBEEF, B=0xCAFEBABE -> 0xB092AB7B88CF5B62; tdata/j hold while stalled.
- rst pulse at beat 10, then A=2, B=2 -> result 4 with no residue from the aborted job; m_res_tdata is held while m_res_tready is low for 5 cycles.

Source files
------------

// File: rtl/mp_mult_pkg.sv
// Shared types and helpers for the multi-precision multiply sequencer.
// Limb widths match the shared 16x16 multiplier core.
package mp_mult_pkg;

    localparam int LIMB_W = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    typedef struct packed {
        int unsigned i;
        int unsigned k;
    } limb_idx_t;

    // Beat index -> (A limb, B limb); B limb varies fastest.
    function automatic limb_idx_t limb_split(input int unsigned beat, input int unsigned limbs);
        limb_idx_t r;
        r.i = beat / limbs;
        r.k = beat % limbs;
        return r;
    endfunction

endpackage

// File: rtl/mp_mult_sequencer.sv
// Schoolbook multi-precision multiplier: streams every limb pair through the
// shared pipelined 16x16 multiplier and shift-accumulates the 32-bit products.
module mp_mult_sequencer
    import mp_mult_pkg::*;
#(
    parameter  int LIMBS    = 4,
    parameter  int MULT_LAT = 4,
    localparam int W        = LIMB_W * LIMBS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        s_op_a_tdata,
    input  logic [W-1:0]        s_op_b_tdata,
    input  logic                s_op_tvalid,
    output logic                s_op_tready,
    output logic [2*W-1:0]      m_res_tdata,
    output logic                m_res_tvalid,
    input  logic                m_res_tready,
    output logic [LIMB_W-1:0]   mul_a_tdata,
    output logic                mul_a_tvalid,
    input  logic                mul_a_tready,
    output logic [LIMB_W-1:0]   mul_b_tdata,
    output logic                mul_b_tvalid,
    input  logic                mul_b_tready,
    input  logic [PROD_W-1:0]   mul_p_tdata,
    input  logic                mul_p_tvalid,
    output logic                mul_p_tready,
    output logic                busy
);

    localparam int N     = LIMBS * LIMBS;
    localparam int BEATS = N + MULT_LAT;
    localparam int JW    = $clog2(BEATS + 1);

    localparam logic [JW-1:0] LAST_J = JW'(BEATS - 1);
    localparam logic [JW-1:0] LAT_J  = JW'(MULT_LAT);
    localparam logic [JW-1:0] N_J    = JW'(N);

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [JW-1:0]       j_q, j_d;
    logic [2*W-1:0]      acc_q, acc_d;
    logic [2*W-1:0]      res_q, res_d;
    logic                res_valid_q, res_valid_d;
    logic                op_ready_q, op_ready_d;
    logic                mul_valid_q, mul_valid_d;
    logic [LIMB_W-1:0]   mul_a_q, mul_a_d;
    logic [LIMB_W-1:0]   mul_b_q, mul_b_d;

    logic [2*W-1:0]      acc_sum;
    limb_idx_t           nxt;
    limb_idx_t           cap;
    logic [JW-1:0]       j_inc;

    // Product alignment comes purely from the beat count.
    logic unused_p_tvalid;
    assign unused_p_tvalid = mul_p_tvalid;

    function automatic logic [LIMB_W-1:0] limb_of(input logic [W-1:0] v, input int unsigned idx);
        return LIMB_W'(v >> (LIMB_W * idx));
    endfunction

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        j_d         = j_q;
        acc_d       = acc_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        op_ready_d  = op_ready_q;
        mul_valid_d = mul_valid_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;

        j_inc   = j_q + 1'b1;
        nxt     = limb_split(32'(j_inc), LIMBS);
        cap     = limb_split(32'(j_q - LAT_J), LIMBS);
        acc_sum = acc_q;
        // The first MULT_LAT samples are whatever was left in the pipeline.
        if (j_q >= LAT_J) begin
            acc_sum = acc_q + ((2*W)'(mul_p_tdata) << (LIMB_W * (cap.i + cap.k)));
        end

        case (state_q)
            IDLE: begin
                if (s_op_tvalid) begin
                    a_d         = s_op_a_tdata;
                    b_d         = s_op_b_tdata;
                    j_d         = '0;
                    acc_d       = '0;
                    mul_valid_d = 1'b1;
                    mul_a_d     = s_op_a_tdata[LIMB_W-1:0];
                    mul_b_d     = s_op_b_tdata[LIMB_W-1:0];
                    op_ready_d  = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mul_a_tready && mul_b_tready) begin
                    acc_d = acc_sum;
                    if (j_q == LAST_J) begin
                        state_d     = DONE;
                        mul_valid_d = 1'b0;
                        mul_a_d     = '0;
                        mul_b_d     = '0;
                        res_d       = acc_sum;
                        res_valid_d = 1'b1;
                        j_d         = '0;
                    end else begin
                        j_d = j_inc;
                        if (j_inc < N_J) begin
                            mul_a_d = limb_of(a_q, nxt.i);
                            mul_b_d = limb_of(b_q, nxt.k);
                        end else begin
                            mul_a_d = '0;
                            mul_b_d = '0;
                        end
                    end
                end
            end
            DONE: begin
                if (m_res_tready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    op_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            op_ready_q  <= op_ready_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign s_op_tready  = op_ready_q;
    assign m_res_tdata  = res_q;
    assign m_res_tvalid = res_valid_q;
    assign mul_a_tdata  = mul_a_q;
    assign mul_b_tdata  = mul_b_q;
    assign mul_a_tvalid = mul_valid_q;
    assign mul_b_tvalid = mul_valid_q;
    assign mul_p_tready = mul_valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mp_mult_sequencer.sv
// Directed bench for mp_mult_sequencer with a behavioural 4-deep 16x16 multiplier.
module tb_mp_mult_sequencer;

    localparam int LIMBS    = 4;
    localparam int MULT_LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   s_op_a_tdata;
    logic [63:0]   s_op_b_tdata;
    logic          s_op_tvalid;
    logic          s_op_tready;
    logic [127:0]  m_res_tdata;
    logic          m_res_tvalid;
    logic          m_res_tready;
    logic [15:0]   mul_a_tdata;
    logic          mul_a_tvalid;
    logic          mul_a_tready;
    logic [15:0]   mul_b_tdata;
    logic          mul_b_tvalid;
    logic          mul_b_tready;
    logic [31:0]   mul_p_tdata;
    logic          mul_p_tvalid;
    logic          mul_p_tready;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int beat_cnt = 0;

    logic [31:0] pipe [MULT_LAT];

    always #5 clk = ~clk;

    mp_mult_sequencer #(.LIMBS(LIMBS), .MULT_LAT(MULT_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_op_a_tdata (s_op_a_tdata),
        .s_op_b_tdata (s_op_b_tdata),
        .s_op_tvalid  (s_op_tvalid),
        .s_op_tready  (s_op_tready),
        .m_res_tdata  (m_res_tdata),
        .m_res_tvalid (m_res_tvalid),
        .m_res_tready (m_res_tready),
        .mul_a_tdata  (mul_a_tdata),
        .mul_a_tvalid (mul_a_tvalid),
        .mul_a_tready (mul_a_tready),
        .mul_b_tdata  (mul_b_tdata),
        .mul_b_tvalid (mul_b_tvalid),
        .mul_b_tready (mul_b_tready),
        .mul_p_tdata  (mul_p_tdata),
        .mul_p_tvalid (mul_p_tvalid),
        .mul_p_tready (mul_p_tready),
        .busy         (busy)
    );

    // Multiplier model: advances only on accepted beats; deliberately not
    // cleared by reset so stale products sit in the pipe.
    initial for (int i = 0; i < MULT_LAT; i++) pipe[i] = 32'h0;

    always @(posedge clk) begin
        if (mul_a_tvalid && mul_b_tvalid && mul_a_tready && mul_b_tready) begin
            pipe[0] <= 32'(mul_a_tdata) * 32'(mul_b_tdata);
            for (int i = 1; i < MULT_LAT; i++) pipe[i] <= pipe[i-1];
            beat_cnt <= beat_cnt + 1;
        end
        if (s_op_tvalid && s_op_tready) beat_cnt <= 0;
    end

    assign mul_p_tdata  = pipe[MULT_LAT-1];
    assign mul_p_tvalid = 1'b1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one operand pair and returns once a result is valid (or timeout).
    task automatic do_job(input logic [63:0] a, input logic [63:0] b,
                          output logic [127:0] res, output int lat,
                          output bit timeout, output bit rdy_busy_err);
        int guard;
        @(negedge clk);
        s_op_a_tdata = a;
        s_op_b_tdata = b;
        s_op_tvalid  = 1'b1;
        guard = 0;
        while (!s_op_tready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        s_op_tvalid  = 1'b0;
        lat          = 1;
        rdy_busy_err = 1'b0;
        while (!m_res_tvalid && lat < 200) begin
            if (s_op_tready || !busy) rdy_busy_err = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (s_op_tready) rdy_busy_err = 1'b1;
        timeout = !m_res_tvalid;
        res     = m_res_tdata;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        s_op_tvalid  = 1'b0;
        s_op_a_tdata = '0;
        s_op_b_tdata = '0;
        m_res_tready = 1'b0;
        mul_a_tready = 1'b1;
        mul_b_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_op_tready, m_res_tvalid, busy, mul_a_tvalid, mul_b_tvalid, mul_p_tready} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/rv/busy/av/bv/pr=%b expected 100000",
                     {s_op_tready, m_res_tvalid, busy, mul_a_tvalid, mul_b_tvalid, mul_p_tready});
        end
        checks++;
        if (m_res_tdata !== 128'h0 || mul_a_tdata !== 16'h0 || mul_b_tdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got res=%h a=%h b=%h expected zeros", m_res_tdata, mul_a_tdata, mul_b_tdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single(input string name, input logic [63:0] a, input logic [63:0] b,
                               input logic [127:0] expv);
        logic [127:0] res;
        int lat;
        bit to, rbe;
        m_res_tready = 1'b0;
        do_job(a, b, res, lat, to, rbe);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout: no result within cycle budget", name);
        end
        checks++;
        if (res !== expv) begin
            errors++;
            $display("FAIL %s_result: got %h expected %h", name, res, expv);
        end
        checks++;
        if (lat !== 21) begin
            errors++;
            $display("FAIL %s_latency: got %0d expected 21", name, lat);
        end
        checks++;
        if (rbe) begin
            errors++;
            $display("FAIL %s_busy: s_op_tready high or busy low during job", name);
        end
        m_res_tready = 1'b1;
        @(posedge clk);
        #1;
        m_res_tready = 1'b0;
        checks++;
        if (m_res_tvalid !== 1'b0 || s_op_tready !== 1'b1) begin
            errors++;
            $display("FAIL %s_consume: got valid=%b ready=%b expected 0 1", name, m_res_tvalid, s_op_tready);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] res;
        int lat;
        bit to, rbe;
        m_res_tready = 1'b1;
        do_job(64'd7, 64'd9, res, lat, to, rbe);
        checks++;
        if (to || res !== 128'd63 || lat !== 21 || rbe) begin
            errors++;
            $display("FAIL b2b_job1: got res=%h lat=%0d to=%b rbe=%b expected 3f 21 0 0", res, lat, to, rbe);
        end
        do_job(64'h1234, 64'h10000, res, lat, to, rbe);
        checks++;
        if (to || res !== 128'h12340000 || lat !== 21 || rbe) begin
            errors++;
            $display("FAIL b2b_job2: got res=%h lat=%0d to=%b rbe=%b expected 12340000 21 0 0", res, lat, to, rbe);
        end
        @(posedge clk);
        #1;
        m_res_tready = 1'b0;
        checks++;
        if (m_res_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got valid=%b busy=%b expected 0 0", m_res_tvalid, busy);
        end
    endtask

    task automatic test_stall();
        logic [63:0] a = 64'hDEADBEEF;
        logic [63:0] b = 64'hCAFEBABE;
        logic [15:0] exp_a, exp_b, prev_a, prev_b;
        logic        prev_stall;
        int n;
        m_res_tready = 1'b0;
        @(negedge clk);
        s_op_a_tdata = a;
        s_op_b_tdata = b;
        s_op_tvalid  = 1'b1;
        checks++;
        if (s_op_tready !== 1'b1) begin
            errors++;
            $display("FAIL stall_idle_ready: got %b expected 1", s_op_tready);
        end
        @(posedge clk);
        #1;
        s_op_tvalid = 1'b0;
        n = 0;
        prev_stall = 1'b0;
        prev_a = '0;
        prev_b = '0;
        while (!m_res_tvalid && n < 400) begin
            exp_a = (beat_cnt < 16) ? 16'(a >> (16 * (beat_cnt / 4))) : 16'h0;
            exp_b = (beat_cnt < 16) ? 16'(b >> (16 * (beat_cnt % 4))) : 16'h0;
            checks++;
            if (mul_a_tdata !== exp_a || mul_b_tdata !== exp_b || mul_a_tvalid !== 1'b1 || mul_b_tvalid !== 1'b1) begin
                errors++;
                $display("FAIL stall_beat%0d: got a=%h b=%h v=%b%b expected a=%h b=%h v=11",
                         beat_cnt, mul_a_tdata, mul_b_tdata, mul_a_tvalid, mul_b_tvalid, exp_a, exp_b);
            end
            if (prev_stall) begin
                checks++;
                if (mul_a_tdata !== prev_a || mul_b_tdata !== prev_b) begin
                    errors++;
                    $display("FAIL stall_hold: got a=%h b=%h expected held a=%h b=%h",
                             mul_a_tdata, mul_b_tdata, prev_a, prev_b);
                end
            end
            prev_a = mul_a_tdata;
            prev_b = mul_b_tdata;
            mul_a_tready = 1'($urandom_range(0, 1));
            mul_b_tready = 1'($urandom_range(0, 1));
            prev_stall = !(mul_a_tready && mul_b_tready);
            @(posedge clk);
            #1;
            n++;
        end
        mul_a_tready = 1'b1;
        mul_b_tready = 1'b1;
        checks++;
        if (m_res_tvalid !== 1'b1 || m_res_tdata !== 128'hB092AB7B88CF5B62) begin
            errors++;
            $display("FAIL stall_result: got valid=%b res=%h expected 1 b092ab7b88cf5b62", m_res_tvalid, m_res_tdata);
        end
        m_res_tready = 1'b1;
        @(posedge clk);
        #1;
        m_res_tready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [127:0] res;
        int lat, guard;
        bit to, rbe, leak;
        m_res_tready = 1'b0;
        @(negedge clk);
        s_op_a_tdata = '1;
        s_op_b_tdata = '1;
        s_op_tvalid  = 1'b1;
        @(posedge clk);
        #1;
        s_op_tvalid = 1'b0;
        guard = 0;
        while (beat_cnt < 10 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (beat_cnt !== 10) begin
            errors++;
            $display("FAIL abort_reach_beat10: got beat %0d expected 10", beat_cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({s_op_tready, m_res_tvalid, busy, mul_a_tvalid, mul_p_tready} !== 5'b10000 || m_res_tdata !== 128'h0
            || mul_a_tdata !== 16'h0 || mul_b_tdata !== 16'h0) begin
            errors++;
            $display("FAIL abort_reset_values: got ctrl=%b res=%h a=%h b=%h expected 10000 0 0 0",
                     {s_op_tready, m_res_tvalid, busy, mul_a_tvalid, mul_p_tready}, m_res_tdata, mul_a_tdata, mul_b_tdata);
        end
        leak = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (m_res_tvalid || busy) leak = 1'b1;
        end
        checks++;
        if (leak) begin
            errors++;
            $display("FAIL abort_no_result: got result/busy after reset expected none");
        end
        do_job(64'd2, 64'd2, res, lat, to, rbe);
        checks++;
        if (to || res !== 128'd4 || lat !== 21) begin
            errors++;
            $display("FAIL abort_next_job: got res=%h lat=%0d to=%b expected 4 21 0", res, lat, to);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (m_res_tvalid !== 1'b1 || m_res_tdata !== 128'd4) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b res=%h expected 1 4", c, m_res_tvalid, m_res_tdata);
            end
        end
        m_res_tready = 1'b1;
        @(posedge clk);
        #1;
        m_res_tready = 1'b0;
        checks++;
        if (m_res_tvalid !== 1'b0 || s_op_tready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got valid=%b ready=%b expected 0 1", m_res_tvalid, s_op_tready);
        end
    endtask

    initial begin
        test_reset();
        test_single("small", 64'd3, 64'd5, 128'd15);
        test_single("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFFFFFFFFFFFFFE_0000000000000001);
        test_single("cross_limb", 64'h0001_0000_0000_0000, 64'h0000_0000_0001_0000,
                    128'h1_0000_0000_0000_0000);
        test_back_to_back();
        test_stall();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
